// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU among NUM_REQ requesters,
// with a single-entry registered response stage tagged by requester ID.
module alu_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 4,
  parameter int ID_WIDTH   = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*CTRL_WIDTH-1:0]  req_op,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_b,
  output logic [DATA_WIDTH-1:0]          alu_data_1,
  output logic [DATA_WIDTH-1:0]          alu_data_2,
  output logic [CTRL_WIDTH-1:0]          alu_control,
  input  logic [DATA_WIDTH-1:0]          alu_result,
  input  logic                           alu_zero,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [DATA_WIDTH-1:0]          rsp_data,
  output logic                           rsp_zero
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state, state_nxt;
  logic [ID_WIDTH-1:0] last_grant, win;
  logic found, can_accept, xfer;
  int idx;
  // Scan from farthest to nearest so the requester closest after last_grant wins.
  always_comb begin
    win = '0;
    found = 1'b0;
    idx = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(last_grant) + k) % NUM_REQ;
      if (req_valid[idx]) begin
        win = ID_WIDTH'(idx);
        found = 1'b1;
      end
    end
  end
  assign rsp_valid   = state == FULL;
  assign can_accept  = !rsp_valid || rsp_ready;
  assign xfer        = found && can_accept;
  assign req_ready   = xfer ? NUM_REQ'(1) << win : '0;
  assign alu_data_1  = found ? req_a[int'(win)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign alu_data_2  = found ? req_b[int'(win)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign alu_control = found ? req_op[int'(win)*CTRL_WIDTH +: CTRL_WIDTH] : '0;
  always_comb begin
    state_nxt = state;
    state_nxt = xfer ? FULL : (can_accept ? EMPTY : state);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= EMPTY;
      rsp_id     <= '0;
      rsp_data   <= '0;
      rsp_zero   <= 1'b0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
    end else begin
      state <= state_nxt;
      if (xfer) begin
        rsp_id     <= win;
        rsp_data   <= alu_result;
        rsp_zero   <= alu_zero;
        last_grant <= win;
      end
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration order, ALU muxing, response
// stage backpressure and asynchronous reset, with a small behavioural ALU.
module tb_alu_arbiter;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  logic clk, rst_n;
  logic [3:0] req_valid, req_ready;
  logic [15:0] req_op;
  logic [127:0] req_a, req_b;
  logic [31:0] alu_data_1, alu_data_2, alu_result, rsp_data;
  logic [3:0] alu_control;
  logic alu_zero, rsp_valid, rsp_ready, rsp_zero;
  logic [1:0] rsp_id;
  int tests, errors;

  alu_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .alu_data_1(alu_data_1), .alu_data_2(alu_data_2), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero)
  );

  assign alu_result = alu_control == OP_ADD ? alu_data_1 + alu_data_2 :
                      alu_control == OP_SUB ? alu_data_1 - alu_data_2 : 32'd0;
  assign alu_zero = alu_result == 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    req_op[i*4 +: 4] = op;
    req_a[i*32 +: 32] = a;
    req_b[i*32 +: 32] = b;
  endtask

  task automatic edge_step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_id;
    tests = 0;
    errors = 0;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b0000;
    req_op = '0;
    req_a = '0;
    req_b = '0;
    #2;
    check("reset rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset rsp_id", 32'(rsp_id), 32'd0);
    check("reset rsp_data", rsp_data, 32'd0);
    check("reset rsp_zero", 32'(rsp_zero), 32'd0);
    check("idle req_ready", 32'(req_ready), 32'd0);
    check("idle alu_data_1", alu_data_1, 32'd0);
    check("idle alu_control", 32'(alu_control), 32'd0);
    edge_step();
    edge_step();
    rst_n = 1'b1;
    // single request from requester 0
    set_req(0, OP_ADD, 32'd7, 32'd5);
    req_valid = 4'b0001;
    #1;
    check("single ready", 32'(req_ready), 32'b0001);
    check("single alu_data_1", alu_data_1, 32'd7);
    check("single alu_data_2", alu_data_2, 32'd5);
    check("single alu_control", 32'(alu_control), 32'(OP_ADD));
    edge_step();
    req_valid = 4'b0000;
    check("single rsp_valid", 32'(rsp_valid), 32'd1);
    check("single rsp_id", 32'(rsp_id), 32'd0);
    check("single rsp_data", rsp_data, 32'd12);
    check("single rsp_zero", 32'(rsp_zero), 32'd0);
    edge_step();
    check("drain rsp_valid", 32'(rsp_valid), 32'd0);
    // zero flag from requester 2
    set_req(2, OP_SUB, 32'd9, 32'd9);
    req_valid = 4'b0100;
    #1;
    check("zero ready", 32'(req_ready), 32'b0100);
    edge_step();
    req_valid = 4'b0000;
    check("zero rsp_id", 32'(rsp_id), 32'd2);
    check("zero rsp_data", rsp_data, 32'd0);
    check("zero rsp_zero", 32'(rsp_zero), 32'd1);
    edge_step();
    // round robin, last_grant = 2 so the order starts at 3
    for (int i = 0; i < 4; i++) set_req(i, OP_ADD, 32'(i * 10), 32'd1);
    req_valid = 4'b1111;
    #1;
    for (int k = 0; k < 8; k++) begin
      exp_id = (3 + k) % 4;
      check("rr ready", 32'(req_ready), 32'(4'b0001 << exp_id));
      edge_step();
      check("rr rsp_valid", 32'(rsp_valid), 32'd1);
      check("rr rsp_id", 32'(rsp_id), 32'(exp_id));
      check("rr rsp_data", rsp_data, 32'(exp_id * 10 + 1));
    end
    // backpressure with requesters 1 and 3 pending, last_grant = 2
    rsp_ready = 1'b0;
    req_valid = 4'b1010;
    #1;
    check("bp ready", 32'(req_ready), 32'd0);
    check("bp alu_data_1", alu_data_1, 32'd30);
    for (int k = 0; k < 3; k++) begin
      edge_step();
      check("bp rsp_valid", 32'(rsp_valid), 32'd1);
      check("bp rsp_id", 32'(rsp_id), 32'd2);
      check("bp rsp_data", rsp_data, 32'd21);
      check("bp ready hold", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    check("bp release ready", 32'(req_ready), 32'b1000);
    edge_step();
    check("bp rsp_id 3", 32'(rsp_id), 32'd3);
    check("bp rsp_data 3", rsp_data, 32'd31);
    check("bp next ready", 32'(req_ready), 32'b0010);
    edge_step();
    check("bp rsp_id 1", 32'(rsp_id), 32'd1);
    // partial contention, last_grant = 1
    req_valid = 4'b1001;
    #1;
    check("pc ready 3", 32'(req_ready), 32'b1000);
    edge_step();
    check("pc rsp_id 3", 32'(rsp_id), 32'd3);
    check("pc ready 0", 32'(req_ready), 32'b0001);
    edge_step();
    check("pc rsp_id 0", 32'(rsp_id), 32'd0);
    check("pc rsp_data 0", rsp_data, 32'd1);
    // asynchronous reset while a response is held and requests pend
    rsp_ready = 1'b0;
    req_valid = 4'b1111;
    edge_step();
    check("pre-reset rsp_valid", 32'(rsp_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async rsp_valid", 32'(rsp_valid), 32'd0);
    check("async rsp_data", rsp_data, 32'd0);
    check("async rsp_id", 32'(rsp_id), 32'd0);
    edge_step();
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    check("post-reset ready", 32'(req_ready), 32'b0001);
    edge_step();
    check("post-reset rsp_id", 32'(rsp_id), 32'd0);
    check("post-reset rsp_data", rsp_data, 32'd1);
    check("post-reset next ready", 32'(req_ready), 32'b0010);
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
